// File: rtl/fetch_unit_pkg.sv
// Shared CPU definitions: opcodes, instruction field positions, fetch state
// encoding and the queue entry layout.
package fetch_unit_pkg;

   localparam int OPC_MSB  = 31;
   localparam int OPC_LSB  = 26;
   localparam int JIMM_MSB = 25;

   localparam logic [5:0] OP_NOP  = 6'b000000;
   localparam logic [5:0] OP_ADD  = 6'b000001;
   localparam logic [5:0] OP_SUB  = 6'b000010;
   localparam logic [5:0] OP_AND  = 6'b000011;
   localparam logic [5:0] OP_OR   = 6'b000100;
   localparam logic [5:0] OP_XOR  = 6'b000101;
   localparam logic [5:0] OP_LDI  = 6'b001000;
   localparam logic [5:0] OP_LD   = 6'b010000;
   localparam logic [5:0] OP_ST   = 6'b010001;
   localparam logic [5:0] OP_BRA  = 6'b010100;
   localparam logic [5:0] OP_JUMP = 6'b010101;
   localparam logic [5:0] OP_HALT = 6'b111111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HALT  = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   function automatic logic is_jump(input logic [31:0] instr);
      return instr[OPC_MSB:OPC_LSB] == OP_JUMP;
   endfunction

   function automatic logic [31:0] jump_target(input logic [31:0] instr);
      return {6'b0, instr[JIMM_MSB:0]};
   endfunction

endpackage

// File: rtl/fetch_unit_inst_queue2.sv
// Two-entry FIFO of {pc, instr}; entry 0 is always the head. Flush wins over
// push and pop in the same cycle.
module inst_queue2
   import fetch_unit_pkg::*;
(
   input  logic         clock,
   input  logic         reset_n,
   input  logic         push,
   input  fetch_entry_t push_entry,
   input  logic         pop,
   input  logic         flush,
   output logic         head_valid,
   output fetch_entry_t head,
   output logic [1:0]   count
);

   fetch_entry_t ent_q [2];
   fetch_entry_t ent_d [2];
   logic [1:0]   count_q;
   logic [1:0]   count_d;
   logic [1:0]   fill;

   // Slot the new entry lands in once this cycle's pop has shifted the queue.
   assign fill = count_q - {1'b0, pop};

   always_comb begin
      ent_d[0] = ent_q[0];
      ent_d[1] = ent_q[1];
      count_d  = count_q;
      if (flush) begin
         count_d = 2'd0;
      end else begin
         if (pop) begin
            ent_d[0] = ent_q[1];
         end
         if (push) begin
            if (fill == 2'd0) begin
               ent_d[0] = push_entry;
            end else begin
               ent_d[1] = push_entry;
            end
         end
         count_d = count_q + {1'b0, push} - {1'b0, pop};
      end
   end

   for (genvar gi = 0; gi < 2; gi++) begin : g_ent
      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            ent_q[gi] <= '0;
         end else begin
            ent_q[gi] <= ent_d[gi];
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= 2'd0;
      end else begin
         count_q <= count_d;
      end
   end

   assign head_valid = (count_q != 2'd0);
   assign head       = ent_q[0];
   assign count      = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: PC register, IDLE/FETCH/HALT control, JUMP
// predecode and the 2-entry instruction queue feeding decode.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'd0,
   parameter int unsigned MEM_WORDS = 25
)
(
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   input  logic        halt_req,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_data,
   output logic        inst_valid,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc,
   input  logic        inst_ready,
   output logic        busy,
   output logic        halted,
   output logic        pc_fault
);

   localparam logic [31:0] MEM_LIMIT = 32'(MEM_WORDS);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic         busy_q, busy_d;
   logic         halted_q, halted_d;
   logic         pc_fault_q, pc_fault_d;

   logic         pop;
   logic         pc_in_range;
   logic         space;
   logic         flush;
   logic         fetch;
   logic [1:0]   q_count;
   fetch_entry_t push_entry;
   fetch_entry_t head;

   assign pop         = inst_valid & inst_ready;
   assign pc_in_range = (pc_q < MEM_LIMIT);
   assign space       = (q_count != 2'd2) || pop;
   assign flush       = redirect_valid && (state_q != ST_IDLE);
   assign fetch       = (state_q == ST_FETCH) && pc_in_range && !redirect_valid && space;
   assign push_entry  = {pc_q, mem_data};

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      pc_fault_d = pc_fault_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (redirect_valid) begin
               pc_d = redirect_pc;
               if (halt_req) begin
                  state_d = ST_HALT;
               end
            end else begin
               if (fetch) begin
                  pc_d = is_jump(mem_data) ? jump_target(mem_data) : pc_q + 32'd1;
               end
               if (!pc_in_range) begin
                  state_d    = ST_HALT;
                  pc_fault_d = 1'b1;
               end else if (halt_req) begin
                  state_d = ST_HALT;
               end
            end
         end
         ST_HALT: begin
            if (redirect_valid) begin
               state_d    = ST_FETCH;
               pc_d       = redirect_pc;
               pc_fault_d = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d   = (state_d == ST_FETCH);
      halted_d = (state_d == ST_HALT);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         pc_q       <= RESET_PC;
         busy_q     <= 1'b0;
         halted_q   <= 1'b0;
         pc_fault_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         busy_q     <= busy_d;
         halted_q   <= halted_d;
         pc_fault_q <= pc_fault_d;
      end
   end

   inst_queue2 u_queue (
      .clock      (clock),
      .reset_n    (reset_n),
      .push       (fetch),
      .push_entry (push_entry),
      .pop        (pop),
      .flush      (flush),
      .head_valid (inst_valid),
      .head       (head),
      .count      (q_count)
   );

   assign mem_addr  = pc_q;
   assign inst_data = head.instr;
   assign inst_pc   = head.pc;
   assign busy      = busy_q;
   assign halted    = halted_q;
   assign pc_fault  = pc_fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: cycle table for startup/stall plus a
// scoreboard of expected decode-side heads for redirect, flush and fault cases.
module tb_fetch_unit;

   logic        clock;
   logic        reset_n;
   logic        start;
   logic        halt_req;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] mem_addr;
   logic [31:0] mem_data;
   logic        inst_valid;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        inst_ready;
   logic        busy;
   logic        halted;
   logic        pc_fault;

   int   checks = 0;
   int   errors = 0;
   logic sb_en  = 1'b0;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
   } sb_t;
   sb_t sb_q[$];

   typedef struct {
      logic        restart;
      logic        ready;
      logic        exp_valid;
      logic [31:0] exp_pc;
      logic [31:0] exp_data;
      logic [31:0] exp_addr;
   } vec_t;
   vec_t vecs[15];

   // Instruction memory image: 21 is JUMP 1, everything else is a non-jump.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'd0)  return 32'h0000_0000;
      if (a == 32'd1)  return 32'h0461_1000;
      if (a == 32'd21) return 32'h5400_0001;
      if (a >= 32'd25) return 32'hFFFF_FFFF;
      return 32'h0800_0000 | a;
   endfunction

   assign mem_data = mem_word(mem_addr);

   fetch_unit #(.RESET_PC(32'd0), .MEM_WORDS(25)) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .start          (start),
      .halt_req       (halt_req),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .mem_addr       (mem_addr),
      .mem_data       (mem_data),
      .inst_valid     (inst_valid),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc),
      .inst_ready     (inst_ready),
      .busy           (busy),
      .halted         (halted),
      .pc_fault       (pc_fault)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset_n        = 1'b0;
      start          = 1'b0;
      halt_req       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'd0;
      inst_ready     = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
   endtask

   // Leaves the bench in the first FETCH cycle.
   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic redirect(input logic [31:0] target);
      redirect_valid = 1'b1;
      redirect_pc    = target;
      tick();
      redirect_valid = 1'b0;
   endtask

   task automatic push_exp(input logic [31:0] pc, input logic [31:0] data);
      sb_q.push_back({pc, data});
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 20; i++) begin
         if (sb_q.size() == 0) break;
         tick();
      end
      chk(name, 32'(sb_q.size()), 32'd0);
   endtask

   // Every head accepted by decode while the scoreboard is armed must match.
   always @(negedge clock) begin
      if (sb_en && reset_n && inst_valid && inst_ready) begin
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got pc %h data %h expected no head", inst_pc, inst_data);
         end else begin
            sb_t e;
            e = sb_q.pop_front();
            if (inst_pc !== e.pc || inst_data !== e.data) begin
               errors++;
               $display("FAIL sb_head: got pc %h data %h expected pc %h data %h",
                        inst_pc, inst_data, e.pc, e.data);
            end else begin
               $display("accept pc %h data %h", inst_pc, inst_data);
            end
         end
      end
   end

   initial begin
      // Startup with decode always ready, then with 5 cycles of backpressure.
      vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'd0, 32'h0000_0000, 32'd0};
      vecs[1]  = '{1'b0, 1'b1, 1'b1, 32'd0, 32'h0000_0000, 32'd1};
      vecs[2]  = '{1'b0, 1'b1, 1'b1, 32'd1, 32'h0461_1000, 32'd2};
      vecs[3]  = '{1'b0, 1'b1, 1'b1, 32'd2, 32'h0800_0002, 32'd3};
      vecs[4]  = '{1'b0, 1'b1, 1'b1, 32'd3, 32'h0800_0003, 32'd4};
      vecs[5]  = '{1'b1, 1'b0, 1'b0, 32'd0, 32'h0000_0000, 32'd0};
      vecs[6]  = '{1'b0, 1'b0, 1'b1, 32'd0, 32'h0000_0000, 32'd1};
      vecs[7]  = '{1'b0, 1'b0, 1'b1, 32'd0, 32'h0000_0000, 32'd2};
      vecs[8]  = '{1'b0, 1'b0, 1'b1, 32'd0, 32'h0000_0000, 32'd2};
      vecs[9]  = '{1'b0, 1'b0, 1'b1, 32'd0, 32'h0000_0000, 32'd2};
      vecs[10] = '{1'b0, 1'b0, 1'b1, 32'd0, 32'h0000_0000, 32'd2};
      vecs[11] = '{1'b0, 1'b1, 1'b1, 32'd0, 32'h0000_0000, 32'd2};
      vecs[12] = '{1'b0, 1'b1, 1'b1, 32'd1, 32'h0461_1000, 32'd3};
      vecs[13] = '{1'b0, 1'b1, 1'b1, 32'd2, 32'h0800_0002, 32'd4};
      vecs[14] = '{1'b0, 1'b1, 1'b1, 32'd3, 32'h0800_0003, 32'd5};

      do_reset();
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_inst_valid", 32'(inst_valid), 32'd0);
      chk("rst_inst_data", inst_data, 32'd0);
      chk("rst_inst_pc", inst_pc, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_pc_fault", 32'(pc_fault), 32'd0);

      for (int i = 0; i < 15; i++) begin
         if (vecs[i].restart) begin
            do_reset();
            do_start();
         end else begin
            tick();
         end
         inst_ready = vecs[i].ready;
         @(negedge clock);
         chk($sformatf("row%0d_valid", i), 32'(inst_valid), 32'(vecs[i].exp_valid));
         chk($sformatf("row%0d_pc", i), inst_pc, vecs[i].exp_pc);
         chk($sformatf("row%0d_data", i), inst_data, vecs[i].exp_data);
         chk($sformatf("row%0d_addr", i), mem_addr, vecs[i].exp_addr);
         chk($sformatf("row%0d_busy", i), 32'(busy), 32'd1);
      end

      // Redirect to the JUMP at 21: head 21 then 1, 2, 3 with no bubble.
      do_reset();
      inst_ready = 1'b1;
      do_start();
      repeat (3) tick();
      redirect(32'd21);
      chk("jmp_mem_addr", mem_addr, 32'd21);
      sb_en = 1'b1;
      push_exp(32'd21, 32'h5400_0001);
      push_exp(32'd1,  32'h0461_1000);
      push_exp(32'd2,  32'h0800_0002);
      push_exp(32'd3,  32'h0800_0003);
      repeat (5) tick();
      chk("jmp_no_bubble", 32'(sb_q.size()), 32'd0);
      sb_en = 1'b0;
      sb_q.delete();

      // Redirect while the queue is full: old entries must never reach decode.
      do_reset();
      do_start();
      repeat (2) tick();
      chk("full_valid", 32'(inst_valid), 32'd1);
      chk("full_stall_addr", mem_addr, 32'd2);
      redirect(32'h10);
      chk("flush_valid", 32'(inst_valid), 32'd0);
      inst_ready = 1'b1;
      sb_en = 1'b1;
      push_exp(32'h10, 32'h0800_0010);
      push_exp(32'h11, 32'h0800_0011);
      push_exp(32'h12, 32'h0800_0012);
      drain("flush_drain");
      sb_en = 1'b0;

      // Sequential run off the end of memory: no pc 25 entry, sticky fault.
      redirect(32'd22);
      sb_en = 1'b1;
      push_exp(32'd22, 32'h0800_0016);
      push_exp(32'd23, 32'h0800_0017);
      push_exp(32'd24, 32'h0800_0018);
      repeat (8) tick();
      chk("oob_drained", 32'(sb_q.size()), 32'd0);
      chk("oob_halted", 32'(halted), 32'd1);
      chk("oob_busy", 32'(busy), 32'd0);
      chk("oob_pc_fault", 32'(pc_fault), 32'd1);
      chk("oob_valid", 32'(inst_valid), 32'd0);
      chk("oob_mem_addr", mem_addr, 32'd25);
      sb_en = 1'b0;

      redirect(32'd3);
      chk("resume_busy", 32'(busy), 32'd1);
      chk("resume_halted", 32'(halted), 32'd0);
      chk("resume_pc_fault", 32'(pc_fault), 32'd0);
      chk("resume_mem_addr", mem_addr, 32'd3);
      sb_en = 1'b1;
      push_exp(32'd3, 32'h0800_0003);
      push_exp(32'd4, 32'h0800_0004);
      drain("resume_drain");
      sb_en = 1'b0;

      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      chk("halt_req_halted", 32'(halted), 32'd1);
      chk("halt_req_busy", 32'(busy), 32'd0);

      // Asynchronous reset mid-stream, checked before any clock edge.
      do_reset();
      inst_ready = 1'b1;
      do_start();
      repeat (3) tick();
      chk("pre_arst_pc", inst_pc, 32'd2);
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_valid", 32'(inst_valid), 32'd0);
      chk("arst_inst_pc", inst_pc, 32'd0);
      chk("arst_inst_data", inst_data, 32'd0);
      chk("arst_mem_addr", mem_addr, 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      #10;
      reset_n = 1'b1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch sequencer for the 32-bit CPU. It owns the program counter, drives the address port of the word-addressed instruction memory, and buffers fetched words in a 2-entry queue. It hands instructions to decode over a valid/ready handshake, predecodes JUMP to redirect early, and accepts branch redirects from execute. It sits between `inst_memory` and the decode stage.

## Interface
- `RESET_PC`, 32'd0: PC loaded at reset.
- `MEM_WORDS`, 25: number of implemented instruction words; valid addresses are 0..MEM_WORDS-1.
- `clock` in 1: sole clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse; leaves IDLE and begins fetching.
- `halt_req` in 1: level; stop fetching at the next edge.
- `redirect_valid` in 1: execute-stage redirect (taken BRA).
- `redirect_pc` in 32: redirect target word address.
- `mem_addr` out 32: instruction memory address, equal to the PC register (combinational).
- `mem_data` in 32: instruction memory read data, valid in the same cycle as `mem_addr`.
- `inst_valid` out 1: queue head is valid.
- `inst_data` out 32: queue head instruction.
- `inst_pc` out 32: queue head word address.
- `inst_ready` in 1: decode accepts the head this cycle.
- `busy` out 1: state is FETCH.
- `halted` out 1: state is HALT.
- `pc_fault` out 1: sticky; a fetch was attempted at PC ≥ MEM_WORDS.

## Operation
- States:
  - IDLE (reset state).
  - FETCH.
  - HALT.
- Transitions:
  - IDLE→FETCH on `start`.
  - FETCH→HALT on `halt_req`, or when PC ≥ MEM_WORDS (also sets `pc_fault`; nothing is enqueued).
  - HALT→FETCH on `redirect_valid` (clears `pc_fault`, loads PC).
  - `start` is ignored outside IDLE. Redirects are ignored in IDLE.
- Fetch condition: state FETCH, PC < MEM_WORDS, no redirect, and the queue has space after this cycle's pop (count < 2, or count == 2 with `inst_valid & inst_ready`).
- On fetch: enqueue {PC, `mem_data`}.
  - If `mem_data[31:26]` == 6'b010101 (JUMP), PC ← {6'b0, `mem_data[25:0]`}.
  - Otherwise PC ← PC + 1.
- No fetch while FETCH and the queue is full: PC holds (stall).
- Redirect in FETCH or HALT:
  - queue flushed (count ← 0, `inst_valid` 0 next cycle);
  - PC ← `redirect_pc`;
  - no enqueue that cycle;
  - a pop in the same cycle is still counted as accepted by decode.
- `redirect_valid` and `halt_req` together in FETCH: the redirect loads PC and flushes, then the state goes to HALT. Redirect target is latched; a later redirect resumes.
- `halt_req` does not flush the queue. Decode drains the remaining entries while in HALT.
- Queue: 2 entries, FIFO order. Push and pop in the same cycle on a full queue is legal and keeps count at 2. Pop on empty is impossible because `inst_valid` is 0.
- PC arithmetic is 32-bit with wrap from 0xFFFFFFFF to 0; the MEM_WORDS check catches it first.

## Timing
- Reset values:
  - PC = RESET_PC, so `mem_addr` = RESET_PC.
  - `inst_valid` 0, `inst_data` 0, `inst_pc` 0.
  - `busy` 0, `halted` 0, `pc_fault` 0.
  - Queue count 0, state IDLE.
- Reset mid-operation clears everything immediately and asynchronously.
- `start` sampled at edge N: FETCH during cycle N+1, first word enqueued at edge N+1, `inst_valid` high in cycle N+2.
- Steady state with `inst_ready` held high: one instruction per cycle.
- JUMP predecode costs zero bubbles; the target is fetched in the next cycle.
- Redirect sampled at edge N: `mem_addr` = target in cycle N+1, and the target instruction is at the head in cycle N+2.
- `inst_data` and `inst_pc` hold stable while `inst_valid & !inst_ready`.

## Structure
- Shared CPU package holds:
  - the opcode constants (JUMP = 6'b010101, plus the full opcode list used by decode);
  - the field slice positions (opcode [31:26], jump immediate [25:0]);
  - the state encoding.
- One sub-module: `inst_queue2`, a 2-entry FIFO of 64-bit {pc, instr} with push/pop/flush and count outputs.
- The top level holds the state machine, PC register and predecode.

## Test plan
- Reset, then `start` with `inst_ready`=1:
  - `inst_valid` rises 2 cycles after `start`;
  - heads are (pc 0, 0x00000000), then (pc 1, 0x04611000), then pc 2, 3, … one per cycle.
- `inst_ready`=0 for 5 cycles after the first valid:
  - queue fills to 2 and `mem_addr` holds at 2;
  - head stays (pc 0) throughout;
  - on release, heads arrive at pc 0, 1, 2 with no loss or duplication.
- Redirect to 21:
  - head (pc 21, 0x54000001), predecoded as JUMP;
  - the next head is (pc 1, 0x04611000) with no bubble.
- `redirect_valid` with `redirect_pc`=0x10 while the queue is full: queue flushed, the next head has pc 0x10, and the old entries never appear.
- Sequential fetch reaching pc 25 with MEM_WORDS=25:
  - HALT, `pc_fault`=1, `halted`=1, and no pc 25 entry;
  - a redirect to 3 resumes FETCH and clears `pc_fault`.
- `reset_n` asserted mid-stream while `inst_valid`=1: outputs drop to reset values asynchronously, with no clock edge required.
